// File: rtl/fpu_pkg.sv
// Shared types and FP32 field helpers for the single-adder request scheduler.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int FRAC_W  = 23;

    // Sign is ignored, so both +0 and -0 count as zero.
    function automatic logic is_zero(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == '0) && (x[FRAC_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping modulo NUM_REQ; returns one-hot and encoded grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        grant     = '0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fpu_add_sched.sv
// Shares one external combinational FP32 adder among NUM_REQ requesters.
// Optional macro FPU_ADD_SCHED_ZERO_BYPASS_EN returns x+0 results without waiting.
module fpu_add_sched
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_sum,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [31:0]           res_data,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(ADD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     add_a_q, add_a_d;
    logic [31:0]     add_b_q, add_b_d;
    logic [31:0]     res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic            res_valid_q, res_valid_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [31:0]        a_sel, b_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot mux of the granted requester's operand slices.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*32 +: 32];
                b_sel = req_b[i*32 +: 32];
            end
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign busy      = (state_q != IDLE);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    add_a_d  = a_sel;
                    add_b_d  = b_sel;
                    res_id_d = grant_idx;
                    cnt_d    = CNT_LOAD;
                    rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                    state_d  = WAIT;
`ifdef FPU_ADD_SCHED_ZERO_BYPASS_EN
                    if (is_zero(a_sel) || is_zero(b_sel)) begin
                        res_data_d  = is_zero(a_sel) ? b_sel : a_sel;
                        res_valid_d = 1'b1;
                        state_d     = RESP;
                    end
`endif
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // The adder has now seen stable operands for ADD_LAT cycles.
                if (cnt_q == CNT_W'(1)) begin
                    res_data_d  = add_sum;
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_fpu_add_sched.sv
// Self-checking bench for fpu_add_sched: directed cases plus a randomized
// phase checked against a round-robin/latency model and a real-valued adder.
module tb_fpu_add_sched;

    localparam int NR = 4;

`ifdef FPU_ADD_SCHED_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    always #5 clk = ~clk;

    // Instance with default latency
    logic [NR-1:0]    req_valid;
    logic [NR*32-1:0] req_a, req_b;
    logic [NR-1:0]    req_ready;
    logic [31:0]      add_a, add_b, add_sum, res_data;
    logic             res_valid, res_ready, busy;
    logic [1:0]       res_id;

    // Instance with ADD_LAT=3
    logic [NR-1:0]    l3_req_valid;
    logic [NR*32-1:0] l3_req_a, l3_req_b;
    logic [NR-1:0]    l3_req_ready;
    logic [31:0]      l3_add_a, l3_add_b, l3_add_sum, l3_res_data;
    logic             l3_res_valid, l3_res_ready, l3_busy;
    logic [1:0]       l3_res_id;

    fpu_add_sched #(.NUM_REQ(NR), .ADD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_ready(res_ready), .busy(busy)
    );

    fpu_add_sched #(.NUM_REQ(NR), .ADD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(l3_req_valid), .req_a(l3_req_a), .req_b(l3_req_b),
        .req_ready(l3_req_ready), .add_a(l3_add_a), .add_b(l3_add_b), .add_sum(l3_add_sum),
        .res_valid(l3_res_valid), .res_id(l3_res_id), .res_data(l3_res_data),
        .res_ready(l3_res_ready), .busy(l3_busy)
    );

    // Behavioural FP32 adder via real arithmetic (normals and zeros only).
    function automatic real to_real(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] from_real(input real v_in);
        real v;
        int  e, f;
        logic s;
        v = v_in;
        s = (v < 0.0);
        if (s) v = -v;
        if (v == 0.0) return 32'h0;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        f = $rtoi((v - 1.0) * 8388608.0 + 0.5);
        if (f >= 8388608) begin f = 0; e++; end
        return {s, 8'(e + 127), 23'(f)};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return from_real(to_real(a) + to_real(b));
    endfunction

    always_comb add_sum    = fp_add(add_a, add_b);
    always_comb l3_add_sum = fp_add(l3_add_a, l3_add_b);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the default instance's result; n = edges waited.
    task automatic wait_res(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    // Round-robin reference: first valid at or after ptr, modulo NR.
    function automatic int pick(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (((mask >> ((ptr + k) % NR)) & 1) != 0) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
    endfunction

    logic [31:0]   rr_sum [NR];
    logic [31:0]   pa [NR];
    logic [31:0]   pb [NR];
    logic [NR-1:0] mask, add_bits;
    int            n, g, mptr, d;

    initial begin
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        l3_req_valid = '0; l3_req_a = '0; l3_req_b = '0; l3_res_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_data", res_data, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_l3_busy", l3_busy, 0);
        rst = 1'b0;

        // Single op: 1.0 + 2.0 from requester 0
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_valid = 4'b0001;
        #1;
        check("single_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("single_busy", busy, 1);
        check("single_ready_wait", req_ready, 0);
        check("single_add_a", add_a, 32'h3F800000);
        check("single_add_b", add_b, 32'h40000000);
        check("single_early_valid", res_valid, 0);
        wait_res(n);
        check("single_lat", 32'(n), 1);
        check("single_id", res_id, 0);
        check("single_data", res_data, 32'h40400000);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("single_done_valid", res_valid, 0);
        check("single_done_busy", busy, 0);

        // Backpressure: requester 1 (5.0+1.0) granted, requester 3 waits
        req_a[63:32]  = 32'h40A00000; req_b[63:32]  = 32'h3F800000;
        req_a[127:96] = 32'h41000000; req_b[127:96] = 32'h41000000;
        req_valid = 4'b1010;
        #1;
        check("bp_ready", req_ready, 4'b0010);
        step();
        req_valid = 4'b1000;
        wait_res(n);
        check("bp_lat", 32'(n), 1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_id", res_id, 1);
            check("bp_hold_data", res_data, 32'h40C00000);
            check("bp_no_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_release", res_valid, 0);
        check("bp_next_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        wait_res(n);
        check("bp_r3_id", res_id, 3);
        check("bp_r3_data", res_data, 32'h41800000);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Mid-op reset while requester 2 is in WAIT
        req_a[95:64] = 32'h40000000; req_b[95:64] = 32'h40000000;
        req_valid = 4'b0100;
        #1;
        check("mid_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_valid", res_valid, 0);
        check("mid_busy", busy, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("mid_no_stale", res_valid, 0);
        end

        // Round robin from a fresh pointer: 1,2,4,8 each plus 2.0
        rr_sum[0] = 32'h40400000; rr_sum[1] = 32'h40800000;
        rr_sum[2] = 32'h40C00000; rr_sum[3] = 32'h41200000;
        for (int i = 0; i < NR; i++) begin
            req_a[i*32 +: 32] = 32'h3F800000 + (32'(i) << 23);
            req_b[i*32 +: 32] = 32'h40000000;
        end
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            g = k % NR;
            check("rr_grant", req_ready, 4'b0001 << g);
            step();
            wait_res(n);
            check("rr_lat", 32'(n), 1);
            check("rr_id", res_id, 32'(g));
            check("rr_data", res_data, rr_sum[g]);
            step();
        end
        req_valid = '0;
        res_ready = 1'b0;
        step();

        // ADD_LAT=3 instance: 1.5 + 2.5
        l3_req_a[31:0] = 32'h3FC00000;
        l3_req_b[31:0] = 32'h40200000;
        l3_req_valid = 4'b0001;
        #1;
        check("lat3_ready", l3_req_ready, 4'b0001);
        step();
        l3_req_valid = '0;
        n = 0;
        while (l3_res_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("lat3_lat", 32'(n), 3);
        check("lat3_id", l3_res_id, 0);
        check("lat3_data", l3_res_data, 32'h40800000);
        l3_res_ready = 1'b1;
        step();
        l3_res_ready = 1'b0;
        check("lat3_done", l3_res_valid, 0);

        // Zero operands: A=+0 then B=-0 (pointer is at 1 after the round robin)
        req_a[63:32] = 32'h00000000; req_b[63:32] = 32'h40400000;
        req_valid = 4'b0010;
        #1;
        check("zero_a_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        check("zero_a_busy", busy, 1);
        wait_res(n);
        check("zero_a_lat", 32'(n), 32'(ZERO_LAT));
        check("zero_a_data", res_data, 32'h40400000);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        req_a[95:64] = 32'h40400000; req_b[95:64] = 32'h80000000;
        req_valid = 4'b0100;
        #1;
        check("zero_b_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        wait_res(n);
        check("zero_b_lat", 32'(n), 32'(ZERO_LAT));
        check("zero_b_id", res_id, 2);
        check("zero_b_data", res_data, 32'h40400000);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Randomized phase against the model
        rst = 1'b1;
        step();
        rst = 1'b0;
        mptr = 0;
        mask = '0;
        for (int it = 0; it < 40; it++) begin
            add_bits = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                if (add_bits[i] && !mask[i]) begin
                    pa[i] = rnd_fp();
                    pb[i] = rnd_fp();
                    req_a[i*32 +: 32] = pa[i];
                    req_b[i*32 +: 32] = pb[i];
                    mask[i] = 1'b1;
                end
            end
            req_valid = mask;
            #1;
            if (mask == '0) begin
                check("rnd_idle_ready", req_ready, 0);
                check("rnd_idle_busy", busy, 0);
                step();
                continue;
            end
            g = pick(mask, mptr);
            check("rnd_grant", req_ready, 4'b0001 << g);
            step();
            mptr = (g + 1) % NR;
            mask = mask & ~(4'b0001 << g);
            req_valid = mask;
            check("rnd_wait_ready", req_ready, 0);
            wait_res(n);
            check("rnd_lat", 32'(n), 1);
            check("rnd_id", res_id, 32'(g));
            check("rnd_data", res_data, fp_add(pa[g], pb[g]));
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                step();
                check("rnd_hold", {res_valid, req_ready, res_data}, {1'b1, 4'b0000, fp_add(pa[g], pb[g])});
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            check("rnd_release", res_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_add_sched.md
Name: fpu_add_sched

Overview:
- Shares one single-precision adder among NUM_REQ requesters.
- Uses round-robin arbitration with a valid/ready request channel per requester.
- Drives the adder's operand inputs and waits a fixed settle latency.
- Returns the sum on a shared, tagged result channel.
- Sits between requesting datapath units and the combinational adder, which is instantiated outside this block and connected through the add_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADD_LAT, 1, cycles operands are held on add_a/add_b before add_sum is sampled (>=1).
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*32  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*32  packed operand B; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- add_a  out  32  operand A to the adder.
- add_b  out  32  operand B to the adder.
- add_sum  in  32  adder result, combinational from add_a/add_b.
- res_valid  out  1  result valid.
- res_id  out  ID_W  index of the requester that owns the result.
- res_data  out  32  IEEE-754 sum.
- res_ready  in  1  result consumer ready.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - state=IDLE; rr_ptr=0; req_ready=0; res_valid=0; res_id=0; res_data=0; add_a=0; add_b=0; busy=0; wait counter=0.
  - Reset mid-operation discards the in-flight op silently; no result is produced.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Grant = first asserted req_valid bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[grant] is driven combinationally while in IDLE; all other req_ready bits are 0.
  - On the handshake edge:
    - latch req_a/req_b slices into add_a/add_b;
    - latch grant into res_id;
    - load the counter with ADD_LAT;
    - rr_ptr = (grant+1) mod NUM_REQ;
    - go to WAIT.
  - No req_valid asserted: stay in IDLE; rr_ptr unchanged.
- WAIT:
  - req_ready=0. add_a/add_b are held stable.
  - The counter decrements each cycle.
  - On the edge where the counter equals 1: res_data <= add_sum; res_valid <= 1; go to RESP.
  - Net timing: handshake at edge n gives res_valid high after edge n+ADD_LAT.
- RESP:
  - res_valid, res_id and res_data are held stable until res_ready=1.
  - On the edge with res_valid&res_ready: res_valid <= 0; go to IDLE.
  - No new request is accepted in the same cycle as the result handshake.
  - Throughput is therefore one op per ADD_LAT+2 cycles minimum.
- Requester obligations: req_valid and operands must stay stable until req_ready. Deassertion of req_valid before grant is allowed; that requester is simply skipped.
- Fairness: each requester with continuously asserted valid is granted within NUM_REQ ops.
- The block does no arithmetic on operands; special values pass straight to the adder.

Optional Feature:
- Macro FPU_ADD_SCHED_ZERO_BYPASS_EN.
- When defined, in IDLE at handshake the operands are checked for zero (exp==0 and frac==0):
  - if A is zero, res_data <= B;
  - else if B is zero, res_data <= A;
  - res_valid <= 1 and go directly to RESP, skipping WAIT; add_a/add_b are still updated.
  - Result is valid after edge n.
- When not defined, all ops take the WAIT path.

Decomposition:
- Package fpu_pkg holds the state enum (IDLE/WAIT/RESP), the FP32 field constants (EXP_MSB=30, EXP_LSB=23, FRAC_W=23) and an is_zero function.
- One sub-module, rr_arbiter (NUM_REQ; inputs req, ptr; output one-hot grant plus encoded grant index), is purely combinational and reusable.

Test Plan:
- Single op: requester 0 sends 3F800000+40000000 (1.0+2.0), adder model attached, ADD_LAT=1 → req_ready[0] in the accept cycle; res_valid after 1 edge in WAIT; res_id=0; res_data=40400000.
- Round robin: all 4 requesters valid continuously, res_ready=1 → grant order 0,1,2,3,0; each res_id matches its requester and operands.
- Backpressure: res_ready=0 for 5 cycles after res_valid → res_data and res_id stay stable, no req_ready pulses; op completes when res_ready=1.
- Mid-op reset: assert rst during WAIT → next cycle res_valid=0, busy=0, rr_ptr=0; no stale result appears afterwards.
- Latency parameter: ADD_LAT=3, 3FC00000+40200000 (1.5+2.5) → res_valid exactly 3 edges after accept; res_data=40800000.
- Bypass (macro defined): A=00000000, B=40400000 → res_valid on the edge after accept, with no WAIT state; res_data=40400000. Without the macro, the same op waits ADD_LAT cycles.
